mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8:1 data multiplexer (3-bit select plus active-low enable) among 8 requesters.
- Drives the mux select lines and enable from registered state.
- Guarantees a one-cycle dead (disabled) slot between owners.
- Bounds how long one requester may hold the mux while others wait.

---
 rtl/mux_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared 8:1 mux (3-bit select, active-low enable).
// Owners are separated by a one-cycle dead slot. A holder is preempted after
// MAX_HOLD cycles when another requester is waiting.
module mux_rr_arbiter #(
  parameter int N_REQ    = 8,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             mux_en_n,
  output logic             busy
);

  localparam int              HC_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(MAX_HOLD);
  localparam logic [N_REQ-1:0] ONE   = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GRANT    = 2'd1,
    S_HANDOVER = 2'd2
  } state_t;

  state_t           r_state,    w_state_nxt;
  logic [N_REQ-1:0] r_gnt,      w_gnt_nxt;
  logic [SEL_W-1:0] r_sel,      w_sel_nxt;
  logic [SEL_W-1:0] r_last_ptr, w_last_nxt;
  logic [HC_W-1:0]  r_hold_cnt, w_hold_nxt;
  logic             r_mux_en_n;
  logic             r_busy;

  logic [SEL_W-1:0] w_pick;
  logic [N_REQ-1:0] w_pick_oh;
  logic             w_any_req;
  logic             w_others;
  logic             w_preempt;

  // First requester found scanning upward from last+1, wrapping; last itself is scanned last.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] rq,
                                               input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last + SEL_W'(k);
      if (!found && rq[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_pick    = rr_pick(req, r_last_ptr);
  assign w_pick_oh = ONE << w_pick;
  assign w_any_req = |req;
  // In GRANT r_gnt is the owner's one-hot, so masking it leaves the waiting requesters.
  assign w_others  = |(req & ~r_gnt);
  assign w_preempt = (MAX_HOLD != 0) && (r_hold_cnt >= HC_MAX) && w_others;

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last_ptr;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      S_IDLE, S_HANDOVER: begin
        if (w_any_req) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = w_pick_oh;
          w_sel_nxt   = w_pick;
          w_hold_nxt  = HC_W'(1);
        end else begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
        end
      end
      S_GRANT: begin
        if (!req[r_sel] || w_preempt) begin
          w_state_nxt = S_HANDOVER;
          w_gnt_nxt   = '0;
          w_last_nxt  = r_sel;
          w_hold_nxt  = '0;
        end else if (r_hold_cnt < HC_MAX) begin
          w_hold_nxt  = r_hold_cnt + HC_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State and registered mux controls; enable and busy follow the next state directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_sel      <= '0;
      r_last_ptr <= SEL_W'(N_REQ - 1);
      r_hold_cnt <= '0;
      r_mux_en_n <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_sel      <= w_sel_nxt;
      r_last_ptr <= w_last_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_mux_en_n <= (w_state_nxt != S_GRANT);
      r_busy     <= (w_state_nxt == S_GRANT);
    end
  end

  assign gnt      = r_gnt;
  assign sel      = r_sel;
  assign mux_en_n = r_mux_en_n;
  assign busy     = r_busy;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: cycle model feeding a scoreboard queue,
// plus directed expectations for the alternation, wrap-around and reset scenarios.
module tb_mux_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req   = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       mux_en_n;
  logic       busy;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       en_n;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  int m_state;  // 0 idle, 1 grant, 2 handover
  int m_owner;
  int m_last;
  int m_hold;
  int m_sel;

  mux_rr_arbiter #(.N_REQ(8), .SEL_W(3), .MAX_HOLD(MAXH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .sel      (sel),
    .mux_en_n (mux_en_n),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_search(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      if (r[(last + k) % 8]) return (last + k) % 8;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_owner = 0;
    m_last  = 7;
    m_hold  = 0;
    m_sel   = 0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic [7:0] r);
    logic [7:0] own_mask;
    case (m_state)
      1: begin
        own_mask = 8'h01 << m_owner;
        if (!r[m_owner] || (m_hold >= MAXH && (r & ~own_mask) != 8'h00)) begin
          m_last  = m_owner;
          m_state = 2;
        end else if (m_hold < MAXH) begin
          m_hold++;
        end
      end
      default: begin
        if (r != 8'h00) begin
          m_owner = m_search(r, m_last);
          m_sel   = m_owner;
          m_hold  = 1;
          m_state = 1;
        end else begin
          m_state = 0;
        end
      end
    endcase
  endtask

  // One clock: drive req, advance the model at the edge, compare just after it.
  task automatic cycle(input logic [7:0] r);
    exp_t e;
    req = r;
    @(posedge clk);
    model_step(r);
    e.gnt  = (m_state == 1) ? (8'h01 << m_owner) : 8'h00;
    e.sel  = 3'(m_sel);
    e.en_n = (m_state != 1);
    e.busy = (m_state == 1);
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    check_val("gnt", gnt, e.gnt);
    check_val("sel", sel, e.sel);
    check_val("mux_en_n", mux_en_n, e.en_n);
    check_val("busy", busy, e.busy);
    check_val("gnt_onehot0", $onehot0(gnt), 1);
    check_val("en_vs_gnt", (gnt != 8'h00), !mux_en_n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check_val("rst_gnt", gnt, 8'h00);
    check_val("rst_en_n", mux_en_n, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat81 [11];
    logic [7:0] m;
    pat81 = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h01};

    // Idle after reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(8'h00);
      check_val("idle_gnt", gnt, 8'h00);
      check_val("idle_sel", sel, 3'd0);
      check_val("idle_busy", busy, 1'b0);
    end

    // Lone requester holds indefinitely
    cycle(8'h01);
    check_val("lone_first_gnt", gnt, 8'h01);
    check_val("lone_first_en", mux_en_n, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(8'h01);
      check_val("lone_hold_gnt", gnt, 8'h01);
    end

    // Two requesters alternate under MAX_HOLD preemption
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cycle(8'h81);
      check_val($sformatf("alt81_gnt_%0d", i), gnt, pat81[i]);
      check_val($sformatf("alt81_en_%0d", i), mux_en_n, (pat81[i] == 8'h00));
    end

    // Wrap-around: after owner 6, search order is 7,0,...
    do_reset();
    cycle(8'h40);
    check_val("wrap_own6", gnt, 8'h40);
    cycle(8'h41);
    check_val("wrap_hold6", gnt, 8'h40);
    cycle(8'h01);
    check_val("wrap_dead_gnt", gnt, 8'h00);
    check_val("wrap_dead_sel", sel, 3'd6);
    cycle(8'h41);
    check_val("wrap_to0", gnt, 8'h01);
    cycle(8'h41);
    check_val("wrap_hold0", gnt, 8'h01);
    cycle(8'h40);
    check_val("wrap_dead2", gnt, 8'h00);
    cycle(8'h40);
    check_val("wrap_back6", gnt, 8'h40);

    // All requesting, each owner leaves after 2 cycles
    do_reset();
    for (int o = 0; o < 9; o++) begin
      m = 8'h01 << (o % 8);
      cycle(8'hFF);
      check_val($sformatf("ff_own_%0d", o), gnt, m);
      cycle(8'hFF);
      check_val($sformatf("ff_hold_%0d", o), gnt, m);
      cycle(8'hFF & ~m);
      check_val($sformatf("ff_dead_%0d", o), mux_en_n, 1'b1);
    end

    // Asynchronous reset in the middle of a grant
    do_reset();
    cycle(8'h08);
    check_val("ar_own3", gnt, 8'h08);
    cycle(8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_gnt", gnt, 8'h00);
    check_val("ar_en_n", mux_en_n, 1'b1);
    check_val("ar_busy", busy, 1'b0);
    check_val("ar_sel", sel, 3'd0);
    #2;
    rst_n = 1'b1;
    model_reset();
    cycle(8'h08);
    check_val("ar_regrant_gnt", gnt, 8'h08);
    check_val("ar_regrant_sel", sel, 3'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
